pkt_router_n: RTL and testbench

Parametrised 1-to-N packet router: one byte-serial ingress stream is steered by a header address field into one of `NUM_PORTS` output FIFOs, each drained by its own reader. It generalises the fixed 3-port, 8-bit router to configurable data width, port count and FIFO depth. It adds length-framed packets, out-of-range address drop and a per-port read-timeout flush. It sits between the ingress serial link and the per-port consumers.

---
 rtl/pkt_router_n_if.sv | 43 ++++
 rtl/pkt_router_n.sv | 253 +++++++++++++++++++++++++
 tb/tb_pkt_router_n.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pkt_router_n_if.sv
// pkt_router_n_if: ingress/egress bundle of the pkt_router_n packet router.
//
// Handshake rules:
//   ingress : a byte on data_in is taken on the rising edge where
//             pkt_valid=1 and busy=0. busy is combinational and can change
//             within a cycle, so the driver holds pkt_valid and data_in
//             until that edge.
//   egress  : port i presents its head byte on data_out[i*DATA_W +: DATA_W]
//             while valid_out[i]=1. Asserting read_en[i] then pops it at
//             the next edge. read_en on an empty port is ignored.
//
// Signals:
//   pkt_valid, data_in    ingress byte and its valid (master -> slave)
//   busy                  ingress stall               (slave -> master)
//   read_en               per-port pop                (master -> slave)
//   data_out, valid_out   per-port head byte and not-empty flag
//   err                   one-cycle parity-mismatch pulse
//   err_addr              one-cycle illegal-address drop pulse
//   soft_reset            per-port one-cycle timeout-flush pulse
interface pkt_router_n_if #(
  parameter int DATA_W    = 8,
  parameter int NUM_PORTS = 3
);
  logic                        pkt_valid;
  logic [DATA_W-1:0]           data_in;
  logic                        busy;
  logic [NUM_PORTS-1:0]        read_en;
  logic [NUM_PORTS*DATA_W-1:0] data_out;
  logic [NUM_PORTS-1:0]        valid_out;
  logic                        err;
  logic                        err_addr;
  logic [NUM_PORTS-1:0]        soft_reset;

  modport master (
    output pkt_valid, data_in, read_en,
    input  busy, data_out, valid_out, err, err_addr, soft_reset
  );

  modport slave (
    input  pkt_valid, data_in, read_en,
    output busy, data_out, valid_out, err, err_addr, soft_reset
  );
endinterface

// File: rtl/pkt_router_n.sv
// pkt_router_n: 1-to-NUM_PORTS byte-serial packet router.
//
// A packet is a header byte (low ADDR_W bits = destination port, upper bits
// = LEN), then LEN payload bytes, then a parity byte when the optional
// parity feature is built in. Every byte of a routed packet, header
// included, is written into the destination port's first-word-fall-through
// FIFO. Packets to an address >= NUM_PORTS are consumed and discarded. A
// port whose head sits unread for TIMEOUT cycles is flushed.
//
// Optional feature macro: PKT_ROUTER_PARITY_EN
//   defined   : a parity byte (XOR of header and payload) ends each packet,
//               is stored with it and checked; a mismatch pulses err.
//   undefined : packets end after LEN payload bytes; err is tied to 0.
//
// Ports:
//   clk        rising-edge clock
//   resetn     synchronous reset, active HIGH (1 = reset)
//   bus        pkt_router_n_if.slave (ingress, per-port egress, pulses)
//   fsm_state  debug view of the ingress FSM
//              (0 IDLE, 1 PAYLOAD, 2 PARITY, 3 DROP)
module pkt_router_n #(
  parameter int DATA_W     = 8,
  parameter int NUM_PORTS  = 3,
  parameter int FIFO_DEPTH = 16,
  parameter int TIMEOUT    = 30
) (
  input  logic                 clk,
  input  logic                 resetn,
  pkt_router_n_if.slave        bus,
  output logic [1:0]           fsm_state
);
  localparam int ADDR_W = $clog2(NUM_PORTS);
  localparam int LEN_W  = DATA_W - ADDR_W;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = $clog2(TIMEOUT);

  localparam logic [ADDR_W:0]  PORTS    = (ADDR_W+1)'(NUM_PORTS);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [PTR_W:0]   PTR_ONE  = (PTR_W+1)'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [LEN_W:0]   ONE      = (LEN_W+1)'(1);
`ifdef PKT_ROUTER_PARITY_EN
  localparam logic [LEN_W:0]   TRAILER  = ONE;
`else
  localparam logic [LEN_W:0]   TRAILER  = '0;
`endif

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
`ifdef PKT_ROUTER_PARITY_EN
    PARITY  = 2'd2,
`endif
    DROP    = 2'd3
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   cur_addr;
  logic [LEN_W:0]      rem;        // bytes still to come in this phase
  logic                err_addr_q;
`ifdef PKT_ROUTER_PARITY_EN
  logic [DATA_W-1:0]   par;
  logic                err_q;
`endif

  logic [DATA_W-1:0]   mem     [NUM_PORTS][FIFO_DEPTH];
  logic [PTR_W:0]      wr_ptr  [NUM_PORTS];
  logic [PTR_W:0]      rd_ptr  [NUM_PORTS];
  logic [CNT_W-1:0]    idle_cnt[NUM_PORTS];
  logic [NUM_PORTS-1:0] soft_reset_q;

  logic [NUM_PORTS-1:0] full, empty, pop, flush, tgt_sel, wr_en;
  logic [ADDR_W-1:0]    hdr_addr;
  logic [LEN_W-1:0]     hdr_len;
  logic                 hdr_legal;
  logic                 tgt_blocked, tgt_flush, accept;
  logic [LEN_W:0]       drop_len, rem_dec, rem_drop;

  assign hdr_addr  = bus.data_in[ADDR_W-1:0];
  assign hdr_len   = bus.data_in[DATA_W-1:ADDR_W];
  assign hdr_legal = {1'b0, hdr_addr} < PORTS;

  // Per-port status. tgt_sel is the port the current ingress byte would be
  // written to: the header's address in IDLE, the latched address while a
  // packet is open, none in DROP (or for an illegal header).
  always_comb begin
    full    = '0;
    empty   = '0;
    pop     = '0;
    flush   = '0;
    tgt_sel = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      empty[i] = (wr_ptr[i] == rd_ptr[i]);
      full[i]  = (wr_ptr[i][PTR_W] != rd_ptr[i][PTR_W]) &&
                 (wr_ptr[i][PTR_W-1:0] == rd_ptr[i][PTR_W-1:0]);
      pop[i]   = bus.read_en[i] && !empty[i];
      flush[i] = !empty[i] && !bus.read_en[i] && (idle_cnt[i] == TMO_LAST);
      if (state == IDLE) begin
        tgt_sel[i] = (hdr_addr == ADDR_W'(i));
      end else if (state != DROP) begin
        tgt_sel[i] = (cur_addr == ADDR_W'(i));
      end
    end
  end

  // A pop in the same cycle frees a slot, so a full target that is being
  // read does not stall ingress.
  assign tgt_blocked = |(tgt_sel & full & ~pop);
  assign accept      = bus.pkt_valid && !tgt_blocked;
  assign tgt_flush   = |(tgt_sel & flush);
  // A write into a port that is being flushed this cycle is discarded.
  assign wr_en       = accept ? (tgt_sel & ~flush) : '0;

  assign drop_len = {1'b0, hdr_len} + TRAILER;
  assign rem_dec  = accept ? (rem - ONE) : rem;
  assign rem_drop = rem_dec + TRAILER;

  assign bus.busy       = tgt_blocked;
  assign bus.valid_out  = ~empty;
  assign bus.soft_reset = soft_reset_q;
  assign bus.err_addr   = err_addr_q;
`ifdef PKT_ROUTER_PARITY_EN
  assign bus.err        = err_q;
`else
  assign bus.err        = 1'b0;
`endif
  assign fsm_state      = state;

  // Head of each FIFO; forced to zero while empty so unwritten storage
  // never shows on data_out.
  always_comb begin
    bus.data_out = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      bus.data_out[i*DATA_W +: DATA_W] =
        empty[i] ? '0 : mem[i][rd_ptr[i][PTR_W-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (wr_en[i]) begin
        mem[i][wr_ptr[i][PTR_W-1:0]] <= bus.data_in;
      end
    end
  end

  // Pointers and idle counters. A flush empties the port outright and
  // takes priority over any same-cycle write or pop.
  always_ff @(posedge clk) begin
    if (resetn) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        wr_ptr[i]   <= '0;
        rd_ptr[i]   <= '0;
        idle_cnt[i] <= '0;
      end
      soft_reset_q <= '0;
    end else begin
      soft_reset_q <= flush;
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (flush[i]) begin
          wr_ptr[i]   <= '0;
          rd_ptr[i]   <= '0;
          idle_cnt[i] <= '0;
        end else begin
          if (wr_en[i]) wr_ptr[i] <= wr_ptr[i] + PTR_ONE;
          if (pop[i])   rd_ptr[i] <= rd_ptr[i] + PTR_ONE;
          if (!empty[i] && !bus.read_en[i]) idle_cnt[i] <= idle_cnt[i] + CNT_ONE;
          else                              idle_cnt[i] <= '0;
        end
      end
    end
  end

  // Ingress FSM. A flush of the open packet's port turns the rest of the
  // packet into a DROP of exactly the bytes still owed by the sender.
  always_ff @(posedge clk) begin
    if (resetn) begin
      state      <= IDLE;
      cur_addr   <= '0;
      rem        <= '0;
      err_addr_q <= 1'b0;
`ifdef PKT_ROUTER_PARITY_EN
      par        <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      err_addr_q <= 1'b0;
`ifdef PKT_ROUTER_PARITY_EN
      err_q      <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (accept) begin
            cur_addr <= hdr_addr;
`ifdef PKT_ROUTER_PARITY_EN
            par      <= bus.data_in;
`endif
            if (!hdr_legal || tgt_flush) begin
              err_addr_q <= !hdr_legal;
              rem        <= drop_len;
              state      <= (drop_len == '0) ? IDLE : DROP;
            end else if (hdr_len != '0) begin
              rem   <= {1'b0, hdr_len};
              state <= PAYLOAD;
            end else begin
`ifdef PKT_ROUTER_PARITY_EN
              state <= PARITY;
`else
              state <= IDLE;
`endif
            end
          end
        end
        PAYLOAD: begin
          if (tgt_flush) begin
            rem   <= rem_drop;
            state <= (rem_drop == '0) ? IDLE : DROP;
          end else if (accept) begin
`ifdef PKT_ROUTER_PARITY_EN
            par <= par ^ bus.data_in;
`endif
            rem <= rem_dec;
            if (rem == ONE) begin
`ifdef PKT_ROUTER_PARITY_EN
              state <= PARITY;
`else
              state <= IDLE;
`endif
            end
          end
        end
`ifdef PKT_ROUTER_PARITY_EN
        PARITY: begin
          if (accept) begin
            err_q <= !tgt_flush && (bus.data_in != par);
            state <= IDLE;
          end else if (tgt_flush) begin
            rem   <= ONE;
            state <= DROP;
          end
        end
`endif
        DROP: begin
          if (accept) begin
            rem <= rem_dec;
            if (rem == ONE) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pkt_router_n.sv
// tb_pkt_router_n: directed bench for pkt_router_n (3 ports, 8-bit bytes,
// 4-deep FIFOs, timeout 30). Builds with or without PKT_ROUTER_PARITY_EN.
// Routed bytes are queued as {port, byte} when the router accepts them; a
// reader process pops enabled ports and checks each byte against the first
// queued entry for that port.
module tb_pkt_router_n;
  localparam int DATA_W     = 8;
  localparam int NUM_PORTS  = 3;
  localparam int FIFO_DEPTH = 4;
  localparam int TIMEOUT    = 30;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_PAYLOAD = 2'd1;
  localparam logic [1:0] S_PARITY  = 2'd2;
  localparam logic [1:0] S_DROP    = 2'd3;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] fsm_state;
  int         cyc = 0;
  int         tests_run = 0;
  int         tests_failed = 0;
  logic [9:0] exp_q[$];
  logic [2:0] rd_mask = 3'b000;
  logic [2:0] pop_req = 3'b000;
  logic [2:0] re;

  pkt_router_n_if #(.DATA_W(DATA_W), .NUM_PORTS(NUM_PORTS)) bus ();

  pkt_router_n #(
    .DATA_W(DATA_W), .NUM_PORTS(NUM_PORTS),
    .FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .resetn(rst), .bus(bus), .fsm_state(fsm_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic sb_pop(input int port, input logic [7:0] d);
    int idx = -1;
    for (int k = 0; k < exp_q.size(); k++)
      if (idx < 0 && exp_q[k][9:8] == port[1:0]) idx = k;
    tests_run++;
    assert (idx >= 0) else begin
      tests_failed++;
      $error("FAIL sb_extra: port %0d observed 0x%0h expected nothing", port, d);
    end
    if (idx >= 0) begin
      check($sformatf("pop_p%0d", port), {24'h0, d}, {24'h0, exp_q[idx][7:0]});
      exp_q.delete(idx);
    end
  endtask

  // Reader: pops every port enabled in rd_mask, plus one-shot pop_req.
  initial begin
    bus.read_en = '0;
    forever begin
      @(negedge clk);
      re = bus.valid_out & (rd_mask | pop_req);
      for (int i = 0; i < NUM_PORTS; i++)
        if (re[i]) sb_pop(i, bus.data_out[i*DATA_W +: DATA_W]);
      bus.read_en = re;
    end
  end

  // ---------------- driver ----------------
  // Offers byte d until accepted; port < 0 means the byte must not appear
  // on any output. Returns #1 after the accepting edge.
  task automatic send_byte(input logic [7:0] d, input int port, output int stalls);
    logic acc;
    acc = 1'b0;
    stalls = 0;
    @(negedge clk);
    bus.pkt_valid = 1'b1;
    bus.data_in   = d;
    for (int n = 0; n < 100 && !acc; n++) begin
      #4;
      if (!bus.busy) begin
        @(posedge clk);
        acc = 1'b1;
      end else begin
        stalls++;
        @(negedge clk);
      end
    end
    #1;
    bus.pkt_valid = 1'b0;
    if (acc && port >= 0) exp_q.push_back({port[1:0], d});
    tests_run++;
    assert (acc) else begin
      tests_failed++;
      $error("FAIL send_accept: byte 0x%0h observed stalled expected accepted", d);
    end
  endtask

  task automatic drain(input string tag);
    for (int n = 0; n < 60 && exp_q.size() != 0; n++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
    check(tag, exp_q.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int st;
    int hdr_cyc;
    logic found;
    logic [7:0] p;

    rst = 1'b1;
    bus.pkt_valid = 1'b0;
    bus.data_in   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",       bus.busy,       0);
    check("rst_valid_out",  bus.valid_out,  0);
    check("rst_data_out",   bus.data_out,   0);
    check("rst_err",        bus.err,        0);
    check("rst_err_addr",   bus.err_addr,   0);
    check("rst_soft_reset", bus.soft_reset, 0);
    check("rst_state",      fsm_state,      S_IDLE);
    @(negedge clk);
    rst = 1'b0;

    // Normal packet: port 1, LEN 3.
    rd_mask = 3'b111;
    send_byte(8'h0D, 1, st);
    check("lat_valid", bus.valid_out[1], 1);
    check("lat_data",  bus.data_out[15:8], 8'h0D);
    p = 8'h0D;
    send_byte(8'h11, 1, st); p = p ^ 8'h11;
    send_byte(8'h22, 1, st); p = p ^ 8'h22;
    send_byte(8'h33, 1, st); p = p ^ 8'h33;
`ifdef PKT_ROUTER_PARITY_EN
    check("norm_state_par", fsm_state, S_PARITY);
    send_byte(p, 1, st);
    check("norm_err", bus.err, 0);
`endif
    check("norm_state_end", fsm_state, S_IDLE);

    // Zero-length packet to port 2.
    send_byte(8'h02, 2, st);
`ifdef PKT_ROUTER_PARITY_EN
    check("len0_state", fsm_state, S_PARITY);
    send_byte(8'h02, 2, st);
    check("len0_err", bus.err, 0);
`endif
    check("len0_state_end", fsm_state, S_IDLE);

`ifdef PKT_ROUTER_PARITY_EN
    // Bad parity: all bytes still delivered, err pulses one cycle.
    send_byte(8'h0D, 1, st);
    send_byte(8'h11, 1, st);
    send_byte(8'h22, 1, st);
    send_byte(8'h33, 1, st);
    send_byte(8'h00, 1, st);
    check("badpar_err", bus.err, 1);
    @(posedge clk); #1;
    check("badpar_err_width", bus.err, 0);
`endif
    drain("drain_normal");
    check("drained_valid", bus.valid_out, 0);

    // Illegal address 3, LEN 2: consumed without stalls, nothing stored.
    send_byte(8'h0B, -1, st);
    check("ill_err_addr", bus.err_addr, 1);
    check("ill_state", fsm_state, S_DROP);
    send_byte(8'hA1, -1, st);
    check("ill_stall1", st, 0);
    check("ill_err_addr_width", bus.err_addr, 0);
    send_byte(8'hA2, -1, st);
    check("ill_stall2", st, 0);
`ifdef PKT_ROUTER_PARITY_EN
    send_byte(8'hA3, -1, st);
    check("ill_stall3", st, 0);
`endif
    check("ill_state_end", fsm_state, S_IDLE);
    check("ill_valid", bus.valid_out, 0);

    // Backpressure: 4-deep port 0, LEN 6, no reads.
    rd_mask = 3'b000;
    p = 8'h18;
    send_byte(8'h18, 0, st);
    send_byte(8'h61, 0, st); p = p ^ 8'h61;
    send_byte(8'h62, 0, st); p = p ^ 8'h62;
    send_byte(8'h63, 0, st); p = p ^ 8'h63;
    check("full_state", fsm_state, S_PAYLOAD);
    @(negedge clk);
    bus.pkt_valid = 1'b1;
    bus.data_in   = 8'h64;
    #4;
    check("full_busy", bus.busy, 1);
    pop_req = 3'b001;
    send_byte(8'h64, 0, st); p = p ^ 8'h64;
    pop_req = 3'b000;
    check("pop_accept_stall", st, 0);
    @(negedge clk);
    bus.pkt_valid = 1'b1;
    bus.data_in   = 8'h65;
    #4;
    check("full_busy_again", bus.busy, 1);
    check("full_valid0", bus.valid_out[0], 1);
    rd_mask = 3'b111;
    send_byte(8'h65, 0, st); p = p ^ 8'h65;
    send_byte(8'h66, 0, st); p = p ^ 8'h66;
`ifdef PKT_ROUTER_PARITY_EN
    send_byte(p, 0, st);
    check("full_err", bus.err, 0);
`endif
    drain("drain_full");

    // Timeout flush of port 2 with a packet still open to it.
    rd_mask = 3'b011;
    send_byte(8'h0E, -1, st);
    hdr_cyc = cyc;
    send_byte(8'h44, -1, st);
    found = 1'b0;
    for (int n = 0; n < 80 && !found; n++) begin
      @(posedge clk); #1;
      if (bus.soft_reset[2]) found = 1'b1;
    end
    check("tmo_seen", found, 1);
    check("tmo_cycle", cyc - hdr_cyc, TIMEOUT);
    check("tmo_valid", bus.valid_out[2], 0);
    check("tmo_others", bus.soft_reset[1:0], 0);
    check("tmo_state", fsm_state, S_DROP);
    @(posedge clk); #1;
    check("tmo_width", bus.soft_reset, 0);
    send_byte(8'h45, -1, st);
    check("tmo_drop_stall1", st, 0);
    send_byte(8'h46, -1, st);
    check("tmo_drop_stall2", st, 0);
`ifdef PKT_ROUTER_PARITY_EN
    send_byte(8'h47, -1, st);
    check("tmo_drop_stall3", st, 0);
`endif
    check("tmo_state_end", fsm_state, S_IDLE);
    check("tmo_valid_end", bus.valid_out[2], 0);
    rd_mask = 3'b111;
    send_byte(8'h06, 2, st);
    send_byte(8'h5A, 2, st);
`ifdef PKT_ROUTER_PARITY_EN
    send_byte(8'h06 ^ 8'h5A, 2, st);
`endif
    drain("drain_tmo");

    // Reset in the middle of a packet.
    rd_mask = 3'b000;
    send_byte(8'h0D, -1, st);
    send_byte(8'h11, -1, st);
    check("mid_state", fsm_state, S_PAYLOAD);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_busy",       bus.busy,       0);
    check("mid_valid_out",  bus.valid_out,  0);
    check("mid_data_out",   bus.data_out,   0);
    check("mid_err",        bus.err,        0);
    check("mid_err_addr",   bus.err_addr,   0);
    check("mid_soft_reset", bus.soft_reset, 0);
    check("mid_state_rst",  fsm_state,      S_IDLE);
    @(negedge clk);
    rst = 1'b0;
    rd_mask = 3'b111;
    send_byte(8'h05, 1, st);
    send_byte(8'h77, 1, st);
`ifdef PKT_ROUTER_PARITY_EN
    send_byte(8'h05 ^ 8'h77, 1, st);
    check("fresh_err", bus.err, 0);
`endif
    drain("drain_fresh");
    check("final_state", fsm_state, S_IDLE);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
